tdm_mem: RTL and testbench

- Time-division-multiplexed memory wrapper: one 1-write/1-read synchronous array is shared by RD_PORTS read channels and one buffered write channel.
- An internal phase counter sequences a frame of 2^PHASE_W cycles: one slot per read port plus a dedicated write slot.
- Parametrised successor of the fixed 4-phase single-read async memory wrapper; exports phase/frame timing for downstream slow-clock logic.

---
 rtl/tdm_mem_pkg.sv | 39 +++
 rtl/tdm_mem_if.sv | 34 +++
 rtl/tdm_mem_array.sv | 36 +++
 rtl/tdm_mem.sv | 156 +++++++++++++++
 tb/tb_tdm_mem.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mem_pkg
// Purpose  : Shared frame-timing constants, slot classification and phase type
//            for the time-division-multiplexed memory wrapper.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_mem_pkg;

    localparam int unsigned TDM_PHASE_W  = 2;
    localparam int unsigned TDM_PHASES   = 1 << TDM_PHASE_W;
    localparam int unsigned TDM_WR_PHASE = TDM_PHASES - 1;

    typedef logic [TDM_PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        SLOT_READ  = 2'd0,
        SLOT_IDLE  = 2'd1,
        SLOT_WRITE = 2'd2
    } slot_e;

    function automatic int unsigned phases_of(input int unsigned pw);
        return 32'd1 << pw;
    endfunction

    // The last phase of every frame belongs to the write channel.
    function automatic slot_e slot_of(input int unsigned ph,
                                      input int unsigned pw,
                                      input int unsigned rd_ports);
        if (ph == phases_of(pw) - 1)
            return SLOT_WRITE;
        else if (ph < rd_ports)
            return SLOT_READ;
        else
            return SLOT_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mem_if
// Purpose  : Bundles frame timing, read channels and the write channel of
//            tdm_mem. slave = memory side, master = requester side.
// Revision : 1.0 - initial release
// ============================================================================
interface tdm_mem_if #(
    parameter int unsigned ELEMENTS_W = 7,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_PORTS   = 2,
    parameter int unsigned PHASE_W    = 2
);
    logic [PHASE_W-1:0]             phase;
    logic                           frame_start;
    logic [RD_PORTS*ELEMENTS_W-1:0] rd_addr;
    logic [RD_PORTS*WIDTH-1:0]      rd_data;
    logic [RD_PORTS-1:0]            rd_valid;
    logic                           wr_valid;
    logic                           wr_ready;
    logic [ELEMENTS_W-1:0]          wr_addr;
    logic [WIDTH-1:0]               wr_data;

    modport slave (
        output phase, frame_start, rd_data, rd_valid, wr_ready,
        input  rd_addr, wr_valid, wr_addr, wr_data
    );

    modport master (
        input  phase, frame_start, rd_data, rd_valid, wr_ready,
        output rd_addr, wr_valid, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/tdm_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mem_array
// Purpose  : 2^ELEMENTS_W x WIDTH storage, one write port and one registered
//            read port. Contents are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mem_array #(
    parameter int unsigned ELEMENTS_W = 7,
    parameter int unsigned WIDTH      = 32
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ELEMENTS_W-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]      i_wdata,
    input  wire logic                  i_re,
    input  wire logic [ELEMENTS_W-1:0] i_raddr,
    output logic      [WIDTH-1:0]      o_rdata
);

    localparam int unsigned DEPTH = 1 << ELEMENTS_W;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/tdm_mem.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mem
// Purpose  : Shares one 1W/1R array between RD_PORTS read channels and a
//            buffered write channel over a 2^PHASE_W-cycle frame.
//            Optional: TDM_MEM_BYPASS_EN forwards the buffered write to reads.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mem
    import tdm_mem_pkg::*;
#(
    parameter int unsigned ELEMENTS_W = 7,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_PORTS   = 2,
    parameter int unsigned PHASE_W    = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    tdm_mem_if.slave  bus
);

    localparam int unsigned PHASES   = phases_of(PHASE_W);
    localparam int unsigned WR_PHASE = PHASES - 1;
    localparam int unsigned PORT_W   = (RD_PORTS > 1) ? $clog2(RD_PORTS) : 1;

    generate
        if (RD_PORTS < 1 || RD_PORTS > WR_PHASE) begin : g_bad_cfg
            $error("tdm_mem: RD_PORTS must be in 1..2^PHASE_W-1");
        end
    endgenerate

    logic [PHASE_W-1:0]          r_phase;
    slot_e                       w_slot;
    logic                        w_rd_issue;
    logic                        w_is_wr_slot;
    logic [PORT_W-1:0]           w_port;
    logic [ELEMENTS_W-1:0]       w_rd_addr;

    logic                        r_buf_valid;
    logic [ELEMENTS_W-1:0]       r_buf_addr;
    logic [WIDTH-1:0]            r_buf_data;
    logic                        w_wr_ready;
    logic                        w_xfer;
    logic                        w_commit;

    logic                        r_iss_vld;
    logic [PORT_W-1:0]           r_iss_port;
    logic [WIDTH-1:0]            w_arr_rdata;
    logic [WIDTH-1:0]            w_cap_data;
    logic [RD_PORTS*WIDTH-1:0]   r_rd_data;
    logic [RD_PORTS-1:0]         r_rd_valid;

    // Frame phase counter; wraps naturally because PHASES is a power of two.
    always_ff @(posedge clk) begin
        if (rst)
            r_phase <= '0;
        else
            r_phase <= r_phase + 1'b1;
    end

    always_comb begin
        w_slot       = slot_of(32'(r_phase), PHASE_W, RD_PORTS);
        w_rd_issue   = (w_slot == SLOT_READ);
        w_is_wr_slot = (w_slot == SLOT_WRITE);
        w_port       = '0;
        w_rd_addr    = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (r_phase == PHASE_W'(p)) begin
                w_port    = PORT_W'(p);
                w_rd_addr = bus.rd_addr[p*ELEMENTS_W +: ELEMENTS_W];
            end
        end
    end

    // Write channel: a one-entry buffer drained only in the write slot.
    assign w_wr_ready = !r_buf_valid || w_is_wr_slot;
    assign w_xfer     = bus.wr_valid && w_wr_ready;
    assign w_commit   = r_buf_valid && w_is_wr_slot;

    always_ff @(posedge clk) begin
        if (rst)
            r_buf_valid <= 1'b0;
        else if (w_xfer)
            r_buf_valid <= 1'b1;
        else if (w_commit)
            r_buf_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_buf_addr <= bus.wr_addr;
            r_buf_data <= bus.wr_data;
        end
    end

    tdm_mem_array #(
        .ELEMENTS_W (ELEMENTS_W),
        .WIDTH      (WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_buf_addr),
        .i_wdata (r_buf_data),
        .i_re    (w_rd_issue),
        .i_raddr (w_rd_addr),
        .o_rdata (w_arr_rdata)
    );

`ifdef TDM_MEM_BYPASS_EN
    logic             r_iss_byp;
    logic [WIDTH-1:0] r_iss_bdata;

    // Snapshot the buffered word at issue so a later reload cannot leak in.
    always_ff @(posedge clk) begin
        if (rst)
            r_iss_byp <= 1'b0;
        else
            r_iss_byp <= w_rd_issue && r_buf_valid && (r_buf_addr == w_rd_addr);
    end

    always_ff @(posedge clk) begin
        if (w_rd_issue)
            r_iss_bdata <= r_buf_data;
    end

    assign w_cap_data = r_iss_byp ? r_iss_bdata : w_arr_rdata;
`else
    assign w_cap_data = w_arr_rdata;
`endif

    // Issue tag follows the array's read register; capture one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_vld  <= 1'b0;
            r_iss_port <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_iss_vld  <= w_rd_issue;
            r_iss_port <= w_port;
            for (int p = 0; p < RD_PORTS; p++) begin
                r_rd_valid[p] <= r_iss_vld && (r_iss_port == PORT_W'(p));
                if (r_iss_vld && (r_iss_port == PORT_W'(p)))
                    r_rd_data[p*WIDTH +: WIDTH] <= w_cap_data;
            end
        end
    end

    assign bus.phase       = r_phase;
    assign bus.frame_start = (r_phase == '0);
    assign bus.wr_ready    = w_wr_ready;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_mem
// Purpose  : Self-checking bench for tdm_mem (3 read ports, 4-phase frame)
//            against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_mem;

    localparam int EW  = 7;
    localparam int DW  = 32;
    localparam int NP  = 3;
    localparam int PW  = 2;
    localparam int NPH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_mem_if #(.ELEMENTS_W(EW), .WIDTH(DW), .RD_PORTS(NP), .PHASE_W(PW)) bus ();

    tdm_mem #(.ELEMENTS_W(EW), .WIDTH(DW), .RD_PORTS(NP), .PHASE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model state
    logic [DW-1:0] mem_m [0:127];
    bit            mem_k [0:127];
    bit            mb_vld;
    logic [EW-1:0] mb_addr;
    logic [DW-1:0] mb_data;
    int            m_cyc;
    bit            pend_v   [NP];
    int            pend_due [NP];
    logic [DW-1:0] pend_val [NP];
    bit            pend_k   [NP];
    logic [DW-1:0] ex_data  [NP];
    bit            ex_k     [NP];
    logic [NP-1:0] ex_valid;
    bit            last_xfer;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [DW-1:0] fillv(input int a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0101_0101);
    endfunction

    function automatic bit model_ready();
        return !mb_vld || ((m_cyc % NPH) == NPH - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        mb_vld = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pend_v[p]  = 1'b0;
            ex_data[p] = '0;
            ex_k[p]    = 1'b1;
        end
    endtask

    // Compare everything the DUT shows in the current cycle.
    task automatic chk();
        @(negedge clk);
        ex_valid = '0;
        for (int p = 0; p < NP; p++) begin
            if (pend_v[p] && pend_due[p] == m_cyc) begin
                ex_data[p]  = pend_val[p];
                ex_k[p]     = pend_k[p];
                ex_valid[p] = 1'b1;
                pend_v[p]   = 1'b0;
            end
        end
        check("phase", 32'(bus.phase), 32'(m_cyc % NPH));
        check("frame_start", 32'(bus.frame_start), 32'((m_cyc % NPH) == 0));
        check("wr_ready", 32'(bus.wr_ready), 32'(model_ready()));
        check("rd_valid", 32'(bus.rd_valid), 32'(ex_valid));
        for (int p = 0; p < NP; p++)
            if (ex_k[p])
                check($sformatf("rd_data%0d", p), bus.rd_data[p*DW +: DW], ex_data[p]);
    endtask

    // Advance the model across one clock edge using the driven inputs.
    task automatic adv();
        int            ph;
        logic [EW-1:0] ra;
        ph        = m_cyc % NPH;
        last_xfer = bus.wr_valid && model_ready();
        if (ph < NP) begin
            ra            = bus.rd_addr[ph*EW +: EW];
            pend_v[ph]    = 1'b1;
            pend_due[ph]  = m_cyc + 2;
            pend_val[ph]  = mem_m[ra];
            pend_k[ph]    = mem_k[ra];
`ifdef TDM_MEM_BYPASS_EN
            if (mb_vld && mb_addr == ra) begin
                pend_val[ph] = mb_data;
                pend_k[ph]   = 1'b1;
            end
`endif
        end
        if (ph == NPH - 1 && mb_vld) begin
            mem_m[mb_addr] = mb_data;
            mem_k[mb_addr] = 1'b1;
            mb_vld         = 1'b0;
        end
        if (last_xfer) begin
            mb_vld  = 1'b1;
            mb_addr = bus.wr_addr;
            mb_data = bus.wr_data;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        chk();
        adv();
    endtask

    task automatic wait_phase(input int ph);
        while ((m_cyc % NPH) != ph)
            tick();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_frame_start", 32'(bus.frame_start), 32'd1);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        for (int p = 0; p < NP; p++)
            check($sformatf("rst_rd_data%0d", p), bus.rd_data[p*DW +: DW], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic write_accept(input logic [EW-1:0] a, input logic [DW-1:0] d);
        int k;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        k = 0;
        do begin
            tick();
            k++;
        end while (!last_xfer && k < 16);
        bus.wr_valid = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [EW-1:0] a);
        bus.rd_addr[p*EW +: EW] = a;
    endtask

    initial begin
        bus.rd_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        for (int a = 0; a < 128; a++) mem_k[a] = 1'b0;
        do_reset();

        // Free-running frame timing
        for (int i = 0; i < 8; i++) begin
            chk();
            check("seq_phase", 32'(bus.phase), 32'(i % 4));
            check("seq_frame_start", 32'(bus.frame_start), 32'((i % 4) == 0));
            adv();
        end

        // Fill the whole array through the write channel
        for (int a = 0; a < 128; a++)
            write_accept(EW'(a), fillv(a));
        repeat (4) tick();

        // Write accepted in phase 1, read back by port 0 after commit
        wait_phase(1);
        set_rd(0, 7'd5);
        write_accept(7'd5, 32'hDEAD_BEEF);
        wait_phase(0);
        tick();
        tick();
        chk();
        check("t2_valid0", 32'(bus.rd_valid[0]), 32'd1);
        check("t2_data0", bus.rd_data[31:0], 32'hDEAD_BEEF);
        adv();

        // Back-pressure while buffer full outside the write slot
        wait_phase(0);
        write_accept(7'd1, 32'h11);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 7'd2;
        bus.wr_data  = 32'h22;
        chk();
        check("t3_stall_ph1", 32'(bus.wr_ready), 32'd0);
        adv();
        chk();
        check("t3_stall_ph2", 32'(bus.wr_ready), 32'd0);
        adv();
        chk();
        check("t3_ready_ph3", 32'(bus.wr_ready), 32'd1);
        adv();
        bus.wr_valid = 1'b0;
        set_rd(0, 7'd1);
        set_rd(1, 7'd2);
        repeat (4) tick();
        tick();
        tick();
        tick();
        chk();
        check("t3_rd0", bus.rd_data[0*DW +: DW], 32'h11);
        check("t3_rd1", bus.rd_data[1*DW +: DW], 32'h22);
        check("t3_valid1", 32'(bus.rd_valid[1]), 32'd1);
        adv();

        // Port 2 result wraps into the next frame's phase 0
        set_rd(2, 7'd7);
        wait_phase(2);
        tick();
        tick();
        chk();
        check("t4_valid2", 32'(bus.rd_valid[2]), 32'd1);
        check("t4_data2", bus.rd_data[2*DW +: DW], fillv(7));
        adv();

        // Reset mid-frame drops the buffered write
        wait_phase(1);
        set_rd(0, 7'd9);
        write_accept(7'd9, 32'h55);
        check("t5_in_phase2", 32'(bus.phase), 32'd2);
        do_reset();
        tick();
        tick();
        chk();
        check("t5_valid0", 32'(bus.rd_valid[0]), 32'd1);
        check("t5_dropped", bus.rd_data[31:0], fillv(9));
        adv();
        repeat (8) tick();

        // Port 0 reads an address whose write is still buffered
        wait_phase(3);
        set_rd(0, 7'd4);
        write_accept(7'd4, 32'hA5);
        tick();
        tick();
        chk();
`ifdef TDM_MEM_BYPASS_EN
        check("t6_forward", bus.rd_data[31:0], 32'hA5);
`else
        check("t6_old", bus.rd_data[31:0], fillv(4));
`endif
        adv();
        wait_phase(2);
        chk();
        check("t6_committed", bus.rd_data[31:0], 32'hA5);
        adv();

        // Randomized traffic on a narrow address range to force collisions
        bus.wr_valid = 1'b0;
        last_xfer    = 1'b0;
        repeat (400) begin
            for (int p = 0; p < NP; p++)
                set_rd(p, EW'($urandom_range(7)));
            if (!(bus.wr_valid && !last_xfer)) begin
                bus.wr_valid = 1'($urandom_range(1));
                bus.wr_addr  = EW'($urandom_range(7));
                bus.wr_data  = $urandom;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
